// File: rtl/seq_div.sv
// =============================================================================
// Module      : seq_div
// Description : Sequential unsigned restoring divider, one quotient bit/clock.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module seq_div #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH_N-1:0] dvd_q, dvd_d;
    logic [WIDTH_D-1:0] dvs_q, dvs_d;
    logic [WIDTH_D-1:0] pr_q, pr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               zero_q, zero_d;
    logic [WIDTH_N-1:0] quotient_q, quotient_d;
    logic [WIDTH_D-1:0] remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    // The partial remainder only needs its 9th bit transiently during the
    // shift; after the compare it is always below the divisor.
    logic [WIDTH_D:0]   w_pr_shift;
    logic               w_fits;
    logic [WIDTH_D-1:0] w_pr_next;
    logic               w_accept;

    assign w_pr_shift = {pr_q, dvd_q[WIDTH_N-1]};
    assign w_fits     = (w_pr_shift >= {1'b0, dvs_q});
    assign w_pr_next  = w_fits ? WIDTH_D'(w_pr_shift - {1'b0, dvs_q})
                               : w_pr_shift[WIDTH_D-1:0];
    assign w_accept   = start && (state_q != CALC);

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        pr_d        = pr_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: state_d = IDLE;
            CALC: begin
                if (zero_q) begin
                    state_d     = FIN;
                    quotient_d  = {WIDTH_N{1'b1}};
                    remainder_d = dvd_q[WIDTH_D-1:0];
                    dbz_d       = 1'b1;
                end else begin
                    // Quotient bits shift into the vacated dividend LSBs.
                    pr_d  = w_pr_next;
                    dvd_d = {dvd_q[WIDTH_N-2:0], w_fits};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d     = FIN;
                        quotient_d  = {dvd_q[WIDTH_N-2:0], w_fits};
                        remainder_d = w_pr_next;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (w_accept) begin
            state_d = CALC;
            dvd_d   = dividend;
            dvs_d   = divisor;
            pr_d    = '0;
            cnt_d   = CNT_W'(WIDTH_N - 1);
            zero_d  = (divisor == '0);
            dbz_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            pr_q        <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            pr_q        <= pr_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == FIN);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: doc/seq_div.md
# seq_div

Sequential unsigned restoring divider: divides a 16-bit dividend by an 8-bit divisor, returning a 16-bit quotient and an 8-bit remainder. It is the inverse companion of the 8x8 array multiplier `ary_mul`. A product from `ary_mul` divided by either of its operands returns the other operand with zero remainder. One quotient bit is resolved per clock behind a start/done handshake.

## Interface
- `WIDTH_N`, 16: dividend and quotient width.
- `WIDTH_D`, 8: divisor and remainder width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled on rising edge, accepted only when `busy`=0.
- `dividend`  in  16  numerator; captured on accepting edge.
- `divisor`  in  8  denominator; captured on accepting edge.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle pulse when results are valid.
- `quotient`  out  16  result; held until next accepted start.
- `remainder`  out  8  result; held until next accepted start.
- `div_by_zero`  out  1  set with `done` when divisor was 0; held with results.

## Operation
- States: IDLE, CALC, FIN.
- IDLE + `start`=1: capture operands and clear the 9-bit partial remainder `pr`.
  - Divisor = 0: go to FIN with `div_by_zero`=1, `quotient`=16'hFFFF, `remainder`=`dividend[7:0]`.
  - Otherwise: load bit counter = 15 and go to CALC.
- CALC, one step per cycle, MSB first:
  - `pr` = {`pr[7:0]`, next dividend bit}.
  - If `pr` >= {1'b0, divisor}: `pr` = `pr` - divisor and the quotient bit = 1. Otherwise the quotient bit = 0.
  - `pr` is 9 bits so the shift never overflows. After the compare, `pr` < divisor <= 255 always holds.
  - After the step for bit 0, go to FIN.
- FIN: `done`=1 for exactly one cycle, `quotient`/`remainder` registered, then go to IDLE.
- FIN behaves as not busy: `start` in the FIN cycle is accepted, and the next operation begins on that edge.
- `start` while `busy`=1 is ignored. Operands are not re-sampled.
- Outputs must satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.
- `quotient` and `remainder` change only on entry to FIN. They must not show intermediate values.
- `div_by_zero` is cleared on the next accepted start.

## Timing
- Reset (async assert, any state): state=IDLE. Outputs `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0. Internal counter and `pr` = 0. Reset asserted mid-CALC aborts the operation and produces no `done`.
- Deassertion of `rst_n` takes effect at the next rising edge. The first `start` can be accepted on that edge.
- Edge E accepts start, divisor != 0:
  - `busy`=1 after E.
  - The 16 CALC steps occur on edges E+1..E+16.
  - FIN is entered after E+16: `done`=1 and results valid; `busy`=0 in the same cycle.
  - `done` drops after E+17.
  - Latency is 17 cycles from the accepting edge to `done` high; throughput is one division per 17 cycles.
- Edge E accepts start, divisor = 0:
  - FIN is entered after E+1: `done`=1 and `busy`=0, with `busy`=1 for the single cycle between.
  - Latency is 2 cycles.
- `busy` and `done` are never high together.

## Test plan
- 200 / 7 -> `quotient`=28, `remainder`=4, `div_by_zero`=0, `done` exactly 17 cycles after the accepting edge.
- 65025 / 255 and 65535 / 1 -> quotient 255, remainder 0; quotient 65535, remainder 0. Then a sweep for all a in 0..255, b in 1..255: dividing a*b by b yields a, remainder 0, cross-checked against `ary_mul` output.
- 100 / 0 -> `done` 2 cycles after start, `div_by_zero`=1, `quotient`=16'hFFFF, `remainder`=100. The next division 9 / 3 -> 3, 0, with `div_by_zero`=0.
- Start 1000 / 10, then pulse `start` with 50 / 5 at cycles 3 and 10 -> both pulses ignored; `quotient`=100, `remainder`=0, single `done`.
- Back-to-back: `start` held high continuously, first 255 / 16 then 17 / 4 -> results 15/15 then 4/1. The second operation is accepted in the FIN cycle, and the two `done` pulses are 17 cycles apart.
- Assert `rst_n`=0 asynchronously mid-CALC of 500 / 3 -> all outputs 0 immediately with no `done`. After release, 500 / 3 -> 166, 2.
